// File: rtl/fc_pkg.sv
// Shared types and constants for the FC-layer input-vector RAM sequencer.
package fc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_PRIME = 3'd2,
      ST_READ  = 3'd3,
      ST_DONE  = 3'd4
   } fc_state_e;

   // The RAM presents this many consecutive words per read address.
   localparam int WIN_WORDS = 16;
   localparam int WIN_SHIFT = $clog2(WIN_WORDS);

endpackage

// File: rtl/fc_ram_seq_if.sv
// Input stream, RAM control and MAC-window handshake bundle.
// slave: the sequencer side; master: the surrounding datapath side.
interface fc_ram_seq_if
   import fc_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 9,
   parameter int NWIDTH = 8
);

   // layer input stream
   logic                        in_valid;
   logic [DWIDTH-1:0]           in_data;
   logic                        in_ready;

   // RAM pins
   logic                        ram_wren;
   logic [AWIDTH-1:0]           ram_waddr;
   logic [DWIDTH-1:0]           ram_din;
   logic [AWIDTH-1:0]           ram_raddr;

   // window handshake towards the MAC array
   logic                        win_valid;
   logic                        win_ready;
   logic [AWIDTH-WIN_SHIFT-1:0] win_idx;
   logic [NWIDTH-1:0]           neuron_idx;
   logic                        win_last;

   modport slave (
      input  in_valid, in_data, win_ready,
      output in_ready, ram_wren, ram_waddr, ram_din, ram_raddr,
             win_valid, win_idx, neuron_idx, win_last
   );

   modport master (
      output in_valid, in_data, win_ready,
      input  in_ready, ram_wren, ram_waddr, ram_din, ram_raddr,
             win_valid, win_idx, neuron_idx, win_last
   );

endinterface

// File: rtl/fc_ram_seq_win_cnt.sv
// Nested window/neuron counter: rd_ptr steps by one window per handshake,
// wraps at the end of the vector and then bumps the neuron index.
module fc_win_cnt
   import fc_pkg::*;
#(
   parameter int AWIDTH  = 9,
   parameter int NWIDTH  = 8,
   parameter int IN_LEN  = 256,
   parameter int OUT_LEN = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,      // restart at window 0, neuron 0
   input  logic                        advance,    // window handshake
   output logic [AWIDTH-1:0]           rd_ptr_nxt, // drives the RAM read address
   output logic [AWIDTH-WIN_SHIFT-1:0] win_idx,
   output logic [NWIDTH-1:0]           neuron_idx,
   output logic                        at_last_win,
   output logic                        at_last_neuron
);

   localparam logic [AWIDTH-1:0] LAST_PTR    = AWIDTH'(IN_LEN - WIN_WORDS);
   localparam logic [AWIDTH-1:0] STEP        = AWIDTH'(WIN_WORDS);
   localparam logic [NWIDTH-1:0] LAST_NEURON = NWIDTH'(OUT_LEN - 1);

   logic [AWIDTH-1:0] rd_ptr;
   logic [NWIDTH-1:0] neuron_nxt;

   assign at_last_win    = (rd_ptr == LAST_PTR);
   assign at_last_neuron = (neuron_idx == LAST_NEURON);
   assign win_idx        = rd_ptr[AWIDTH-1:WIN_SHIFT];

   // Next pointer/neuron; the final handshake wraps rd_ptr but holds the neuron.
   always_comb begin
      rd_ptr_nxt = rd_ptr;
      neuron_nxt = neuron_idx;
      if (clear) begin
         rd_ptr_nxt = '0;
         neuron_nxt = '0;
      end else if (advance) begin
         if (at_last_win) begin
            rd_ptr_nxt = '0;
            if (!at_last_neuron)
               neuron_nxt = neuron_idx + 1'b1;
         end else begin
            rd_ptr_nxt = rd_ptr + STEP;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr     <= '0;
         neuron_idx <= '0;
      end else begin
         rd_ptr     <= rd_ptr_nxt;
         neuron_idx <= neuron_nxt;
      end
   end

endmodule

// File: rtl/fc_ram_seq.sv
// FC-layer input-vector RAM sequencer: loads IN_LEN words, then replays the
// vector OUT_LEN times as 16-word windows with valid/ready backpressure.
module fc_ram_seq
   import fc_pkg::*;
#(
   parameter int DWIDTH  = 16,
   parameter int AWIDTH  = 9,
   parameter int IN_LEN  = 256,
   parameter int OUT_LEN = 10,
   parameter int NWIDTH  = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         busy,
   output logic         done,
   fc_ram_seq_if.slave  bus
);

   localparam logic [AWIDTH-1:0] LAST_WADDR = AWIDTH'(IN_LEN - 1);

   fc_state_e         state, state_nxt;
   logic [AWIDTH-1:0] wr_ptr, wr_ptr_nxt;
   logic              accept;
   logic              win_hs;
   logic              at_last_win;
   logic              at_last_neuron;

   assign accept = (state == ST_LOAD) && bus.in_valid;
   assign win_hs = (state == ST_READ) && bus.win_ready;

   fc_win_cnt #(
      .AWIDTH  (AWIDTH),
      .NWIDTH  (NWIDTH),
      .IN_LEN  (IN_LEN),
      .OUT_LEN (OUT_LEN)
   ) u_win_cnt (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (state == ST_PRIME),
      .advance        (win_hs),
      .rd_ptr_nxt     (bus.ram_raddr),
      .win_idx        (bus.win_idx),
      .neuron_idx     (bus.neuron_idx),
      .at_last_win    (at_last_win),
      .at_last_neuron (at_last_neuron)
   );

   // State and write-pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         wr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         wr_ptr <= wr_ptr_nxt;
      end
   end

   // Next-state and write-pointer logic.
   always_comb begin
      state_nxt  = state;
      wr_ptr_nxt = wr_ptr;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt  = ST_LOAD;
               wr_ptr_nxt = '0;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               wr_ptr_nxt = wr_ptr + 1'b1;
               if (wr_ptr == LAST_WADDR)
                  state_nxt = ST_PRIME;
            end
         end
         // One idle RAM cycle so it latches read address 0 after the last write.
         ST_PRIME: state_nxt = ST_READ;
         ST_READ: begin
            if (win_hs && at_last_win && at_last_neuron)
               state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Write path is a pass-through of the input stream while loading.
   assign bus.in_ready  = (state == ST_LOAD);
   assign bus.ram_wren  = accept;
   assign bus.ram_waddr = (state == ST_LOAD) ? wr_ptr : '0;
   assign bus.ram_din   = (state == ST_LOAD) ? bus.in_data : '0;

   assign bus.win_valid = (state == ST_READ);
   assign bus.win_last  = (state == ST_READ) && at_last_win;

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_fc_ram_seq.sv
// Self-checking bench for fc_ram_seq with a behavioural 16-wide read RAM.
module tb_fc_ram_seq;
   import fc_pkg::*;

   localparam int DW   = 16;
   localparam int AW   = 9;
   localparam int IL   = 32;
   localparam int OL   = 2;
   localparam int NW   = 8;
   localparam int NWIN = IL / 16;
   localparam int TOT  = OL * NWIN;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, done;

   fc_ram_seq_if #(.DWIDTH(DW), .AWIDTH(AW), .NWIDTH(NW)) bus ();

   fc_ram_seq #(.DWIDTH(DW), .AWIDTH(AW), .IN_LEN(IL), .OUT_LEN(OL), .NWIDTH(NW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // RAM: one write port; read address is latched on any non-write cycle
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [AW-1:0] raddr_q;
   always @(posedge clk) begin
      if (bus.ram_wren) mem[bus.ram_waddr] <= bus.ram_din;
      else              raddr_q <= bus.ram_raddr;
   end

   function automatic logic [DW-1:0] ram_word(input int k);
      return mem[raddr_q + AW'(k)];
   endfunction

   int n_chk = 0;
   int n_err = 0;
   logic [DW-1:0] vec [0:IL-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_win_valid"}, bus.win_valid, 0);
      chk({tag, "_neuron"}, bus.neuron_idx, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // in_mode: 0 always valid, 1 toggling, 2 random
   // rdy_mode: 0 always ready, 1 five-cycle stall on neuron 0 window 1, 2 random
   // abort_win: reset while this window is presented (-1 = never)
   // poke: pulse start and wiggle in_valid while busy
   task automatic run_seq(input int in_mode, input int rdy_mode, input int abort_win, input bit poke);
      int idx, loadc, readc, wins, stall, n, w, exp_ra;
      logic acc, hs;
      @(negedge clk);
      start = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("load_busy", busy, 1);
      idx = 0; loadc = 0;
      while (idx < IL && loadc < 4 * IL) begin
         case (in_mode)
            0:       bus.in_valid = 1'b1;
            1:       bus.in_valid = (loadc % 2 == 0);
            default: bus.in_valid = 1'($urandom_range(0, 1));
         endcase
         bus.in_data = bus.in_valid ? vec[idx] : DW'($urandom);
         start = poke && (loadc == 3);
         #1;
         chk("load_in_ready", bus.in_ready, 1);
         chk("load_wren", bus.ram_wren, bus.in_valid);
         chk("load_done", done, 0);
         if (bus.in_valid) begin
            chk("load_waddr", bus.ram_waddr, idx);
            chk("load_din", bus.ram_din, vec[idx]);
         end
         acc = bus.in_valid;
         @(posedge clk);
         loadc++;
         if (acc) idx++;
         @(negedge clk);
      end
      chk("load_complete", idx, IL);
      // PRIME cycle
      start = poke;
      bus.in_valid = poke;
      bus.in_data = DW'($urandom);
      #1;
      chk("prime_in_ready", bus.in_ready, 0);
      chk("prime_wren", bus.ram_wren, 0);
      chk("prime_win_valid", bus.win_valid, 0);
      chk("prime_raddr", bus.ram_raddr, 0);
      chk("prime_busy", busy, 1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < IL; i++) chk("ram_content", mem[i], vec[i]);
      wins = 0; readc = 0; stall = 0;
      while (wins < TOT && readc < 8 * TOT) begin
         n = wins / NWIN;
         w = wins % NWIN;
         chk("rd_win_valid", bus.win_valid, 1);
         chk("rd_win_idx", bus.win_idx, w);
         chk("rd_neuron", bus.neuron_idx, n);
         chk("rd_win_last", bus.win_last, (w == NWIN - 1));
         chk("rd_done", done, 0);
         for (int k = 0; k < 16; k++) chk("rd_data", ram_word(k), vec[w * 16 + k]);
         case (rdy_mode)
            0: bus.win_ready = 1'b1;
            1: begin
               bus.win_ready = !(n == 0 && w == 1 && stall < 5);
               if (!bus.win_ready) stall++;
            end
            default: bus.win_ready = 1'($urandom_range(0, 1));
         endcase
         start = poke && (readc == 2);
         bus.in_valid = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         chk("rd_wren", bus.ram_wren, 0);
         chk("rd_in_ready", bus.in_ready, 0);
         chk("rd_busy", busy, 1);
         if (!bus.win_ready) chk("rd_raddr_hold", bus.ram_raddr, w * 16);
         else if (wins + 1 < TOT) chk("rd_raddr_next", bus.ram_raddr, ((wins + 1) % NWIN) * 16);
         if (wins == abort_win) begin
            rst_n = 1'b0;
            #1;
            idle_outputs("abort");
            chk("abort_win_idx", bus.win_idx, 0);
            chk("abort_wren", bus.ram_wren, 0);
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            bus.win_ready = 1'b0;
            start = 1'b0;
            bus.in_valid = 1'b0;
            #1;
            idle_outputs("post_abort");
            return;
         end
         hs = bus.win_ready;
         @(posedge clk);
         readc++;
         if (hs) wins++;
         @(negedge clk);
      end
      chk("read_complete", wins, TOT);
      start = 1'b0;
      bus.in_valid = 1'b0;
      bus.win_ready = 1'b0;
      #1;
      chk("done_pulse", done, 1);
      chk("done_win_valid", bus.win_valid, 0);
      chk("done_busy", busy, 1);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("done_drop", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_win_valid", bus.win_valid, 0);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.win_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      idle_outputs("reset");
      chk("reset_wren", bus.ram_wren, 0);
      chk("reset_win_last", bus.win_last, 0);
      chk("reset_waddr", bus.ram_waddr, 0);
      chk("reset_din", bus.ram_din, 0);
      chk("reset_win_idx", bus.win_idx, 0);
      rst_n = 1'b1;

      // in_valid while idle must not write
      repeat (3) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data = DW'($urandom);
         #1;
         chk("idle_wren", bus.ram_wren, 0);
         chk("idle_in_ready", bus.in_ready, 0);
         chk("idle_busy", busy, 0);
      end
      bus.in_valid = 1'b0;

      // ramp vector, no gaps, no stalls: done lands at the nominal cycle count
      for (int i = 0; i < IL; i++) vec[i] = DW'(16'h0100 + i);
      run_seq(0, 0, -1, 1'b0);

      // five-cycle stall on neuron 0 window 1
      for (int i = 0; i < IL; i++) vec[i] = DW'($urandom);
      run_seq(0, 1, -1, 1'b0);

      // toggling in_valid, random ready, stray start / in_valid while busy
      for (int i = 0; i < IL; i++) vec[i] = DW'($urandom);
      run_seq(1, 2, -1, 1'b1);

      // reset on neuron 1 window 1, then reload a fresh vector
      for (int i = 0; i < IL; i++) vec[i] = DW'($urandom);
      run_seq(2, 0, 3, 1'b0);
      for (int i = 0; i < IL; i++) vec[i] = DW'($urandom);
      run_seq(0, 2, -1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
